dcache_tl_c_arbiter: RTL and testbench

Arbiter and sequencer for the data cache's TileLink channel C. It shares the single C port between the probe unit (ProbeAck/ProbeAckData) and the writeback unit (Release/ReleaseData). Multi-beat data bursts are locked to one requester until their last beat. The block also tracks the outstanding Release until its ReleaseAck returns on channel D. It sits between the dcache probe/writeback units and the C-channel output toward the bus.

---
 rtl/dcache_tl_c_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_dcache_tl_c_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_tl_c_arbiter.sv
// -----------------------------------------------------------------------------
// dcache_tl_c_arbiter
//
// Shares the data cache's single TileLink channel C port between the probe
// unit (ProbeAck / ProbeAckData) and the writeback unit (Release /
// ReleaseData). Multi-beat data bursts stay locked to one requester until
// their last beat, and the outstanding Release is tracked until its
// ReleaseAck comes back on channel D.
//
// Ports
//   clock, reset_n          sole clock (rising edge), async active-low reset
//   prb_* / wb_*            requester bundles: valid/ready handshake plus
//                           opcode, param, size, source, address, data
//   c_*                     channel C output, muxed from the granted requester
//   d_release_ack           one-cycle pulse: ReleaseAck accepted on channel D
//   rel_pending             a Release was sent and its ReleaseAck is awaited
//   busy                    a multi-beat burst is in progress
//   proto_err               sticky protocol-error flag
// -----------------------------------------------------------------------------
module dcache_tl_c_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 64,
   parameter int SRC_W      = 2,
   parameter int SIZE_W     = 4,
   parameter int LINE_BYTES = 64
) (
   input  logic              clock,
   input  logic              reset_n,

   input  logic              prb_valid,
   output logic              prb_ready,
   input  logic [2:0]        prb_opcode,
   input  logic [2:0]        prb_param,
   input  logic [SIZE_W-1:0] prb_size,
   input  logic [SRC_W-1:0]  prb_source,
   input  logic [ADDR_W-1:0] prb_address,
   input  logic [DATA_W-1:0] prb_data,

   input  logic              wb_valid,
   output logic              wb_ready,
   input  logic [2:0]        wb_opcode,
   input  logic [2:0]        wb_param,
   input  logic [SIZE_W-1:0] wb_size,
   input  logic [SRC_W-1:0]  wb_source,
   input  logic [ADDR_W-1:0] wb_address,
   input  logic [DATA_W-1:0] wb_data,

   output logic              c_valid,
   input  logic              c_ready,
   output logic [2:0]        c_opcode,
   output logic [2:0]        c_param,
   output logic [SIZE_W-1:0] c_size,
   output logic [SRC_W-1:0]  c_source,
   output logic [ADDR_W-1:0] c_address,
   output logic [DATA_W-1:0] c_data,

   input  logic              d_release_ack,
   output logic              rel_pending,
   output logic              busy,
   output logic              proto_err
);

   localparam int BEAT_BYTES = DATA_W / 8;
   localparam int BEAT_LG    = $clog2(BEAT_BYTES);
   localparam int LINE_LG    = $clog2(LINE_BYTES);
   localparam int MAX_BEATS  = LINE_BYTES / BEAT_BYTES;
   localparam int CNT_W      = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

   localparam logic [SIZE_W-1:0] BEAT_LG_S = SIZE_W'(BEAT_LG);
   localparam logic [SIZE_W-1:0] LINE_LG_S = SIZE_W'(LINE_LG);
   localparam logic [CNT_W:0]    MAX_M1    = (CNT_W+1)'(MAX_BEATS - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

   localparam logic [2:0] OP_PROBE_ACK_DATA = 3'd5;
   localparam logic [2:0] OP_RELEASE        = 3'd6;
   localparam logic [2:0] OP_RELEASE_DATA   = 3'd7;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      PRB_BURST = 2'd1,
      WB_BURST  = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rel_pending_q, rel_pending_d;
   logic             proto_err_q, proto_err_d;

   logic             grant_prb, grant_wb;
   logic             wb_is_release;
   logic             is_data;
   logic [CNT_W:0]   beats_m1;
   logic             size_err;
   logic             fire, last_fire, rel_set;

   // ---------------------------------------------------------------------------
   // Grant. In IDLE the decision is purely combinational so a beat can leave
   // in the same cycle it is offered. Probe wins outright: probe acks must
   // always make progress or the coherence protocol can deadlock. A new
   // Release waits while the previous one is still unacknowledged.
   // ---------------------------------------------------------------------------
   assign wb_is_release = (wb_opcode == OP_RELEASE) || (wb_opcode == OP_RELEASE_DATA);

   always_comb begin
      // NOTE: every signal assigned in always_comb gets a default up front;
      // a path that leaves one unassigned would infer a latch.
      grant_prb = 1'b0;
      grant_wb  = 1'b0;
      unique case (state_q)
         IDLE: begin
            grant_prb = prb_valid;
            grant_wb  = !prb_valid && wb_valid && !(rel_pending_q && wb_is_release);
         end
         PRB_BURST: grant_prb = 1'b1;
         WB_BURST:  grant_wb  = 1'b1;
         default: ;
      endcase
   end

   // Payload defaults to the writeback bundle whenever probe is not granted.
   assign c_valid   = (grant_prb && prb_valid) || (grant_wb && wb_valid);
   assign c_opcode  = grant_prb ? prb_opcode  : wb_opcode;
   assign c_param   = grant_prb ? prb_param   : wb_param;
   assign c_size    = grant_prb ? prb_size    : wb_size;
   assign c_source  = grant_prb ? prb_source  : wb_source;
   assign c_address = grant_prb ? prb_address : wb_address;
   assign c_data    = grant_prb ? prb_data    : wb_data;

   assign prb_ready = grant_prb && c_ready;
   assign wb_ready  = grant_wb  && c_ready;

   // ---------------------------------------------------------------------------
   // Burst length of the message currently on the port, as beats minus one.
   // Only meaningful on a first beat (IDLE); bursts then run off the counter.
   // One extra bit holds the full shift result before the subtraction.
   // ---------------------------------------------------------------------------
   assign is_data = (c_opcode == OP_PROBE_ACK_DATA) || (c_opcode == OP_RELEASE_DATA);

   always_comb begin
      beats_m1 = '0;
      size_err = 1'b0;
      if (is_data && (c_size >= BEAT_LG_S)) begin
         if (c_size > LINE_LG_S) begin
            // Oversized message: flag it and send a full line.
            beats_m1 = MAX_M1;
            size_err = 1'b1;
         end else begin
            beats_m1 = ((CNT_W+1)'(1) << (c_size - BEAT_LG_S)) - (CNT_W+1)'(1);
         end
      end
   end

   assign fire      = c_valid && c_ready;
   assign last_fire = fire && ((state_q == IDLE) ? (beats_m1 == '0) : (cnt_q == CNT_ONE));
   assign rel_set   = last_fire && ((c_opcode == OP_RELEASE) || (c_opcode == OP_RELEASE_DATA));

   // ---------------------------------------------------------------------------
   // Next-state logic.
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            // Single-beat messages never leave IDLE.
            if (fire && (beats_m1 != '0)) begin
               cnt_d   = beats_m1[CNT_W-1:0];
               state_d = grant_prb ? PRB_BURST : WB_BURST;
            end
         end
         PRB_BURST, WB_BURST: begin
            if (fire) begin
               cnt_d = cnt_q - CNT_ONE;
               if (cnt_q == CNT_ONE) begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A set on the last Release beat beats a same-cycle ack; an ack with no
   // Release outstanding (including that same-cycle case) is a protocol error.
   assign rel_pending_d = rel_set ? 1'b1 : (d_release_ack ? 1'b0 : rel_pending_q);

   assign proto_err_d = proto_err_q
                      || (fire && (state_q == IDLE) && size_err)
                      || (d_release_ack && !rel_pending_q);

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         rel_pending_q <= 1'b0;
         proto_err_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         rel_pending_q <= rel_pending_d;
         proto_err_q   <= proto_err_d;
      end
   end

   assign rel_pending = rel_pending_q;
   assign proto_err   = proto_err_q;
   assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_dcache_tl_c_arbiter.sv
// -----------------------------------------------------------------------------
// Directed testbench for dcache_tl_c_arbiter (default parameters: 64-bit
// beats, 64-byte lines, so size 6 = 8 beats). Inputs change just after the
// rising edge; combinational outputs are checked 1 ns later and registered
// outputs 1 ns after the following edge.
// -----------------------------------------------------------------------------
module tb_dcache_tl_c_arbiter;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 64;
   localparam int SRC_W  = 2;
   localparam int SIZE_W = 4;

   logic              clock = 1'b0;
   logic              reset_n;
   logic              prb_valid, prb_ready;
   logic [2:0]        prb_opcode, prb_param;
   logic [SIZE_W-1:0] prb_size;
   logic [SRC_W-1:0]  prb_source;
   logic [ADDR_W-1:0] prb_address;
   logic [DATA_W-1:0] prb_data;
   logic              wb_valid, wb_ready;
   logic [2:0]        wb_opcode, wb_param;
   logic [SIZE_W-1:0] wb_size;
   logic [SRC_W-1:0]  wb_source;
   logic [ADDR_W-1:0] wb_address;
   logic [DATA_W-1:0] wb_data;
   logic              c_valid, c_ready;
   logic [2:0]        c_opcode, c_param;
   logic [SIZE_W-1:0] c_size;
   logic [SRC_W-1:0]  c_source;
   logic [ADDR_W-1:0] c_address;
   logic [DATA_W-1:0] c_data;
   logic              d_release_ack, rel_pending, busy, proto_err;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clock = ~clock;

   dcache_tl_c_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SRC_W(SRC_W), .SIZE_W(SIZE_W), .LINE_BYTES(64)
   ) dut (
      .clock(clock), .reset_n(reset_n),
      .prb_valid(prb_valid), .prb_ready(prb_ready), .prb_opcode(prb_opcode),
      .prb_param(prb_param), .prb_size(prb_size), .prb_source(prb_source),
      .prb_address(prb_address), .prb_data(prb_data),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_opcode(wb_opcode),
      .wb_param(wb_param), .wb_size(wb_size), .wb_source(wb_source),
      .wb_address(wb_address), .wb_data(wb_data),
      .c_valid(c_valid), .c_ready(c_ready), .c_opcode(c_opcode), .c_param(c_param),
      .c_size(c_size), .c_source(c_source), .c_address(c_address), .c_data(c_data),
      .d_release_ack(d_release_ack), .rel_pending(rel_pending), .busy(busy),
      .proto_err(proto_err)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive_prb(input logic v, input logic [2:0] op, input logic [3:0] sz,
                            input logic [31:0] addr, input logic [63:0] d);
      prb_valid = v; prb_opcode = op; prb_size = sz; prb_address = addr; prb_data = d;
      prb_param = 3'd1; prb_source = 2'd1;
   endtask

   task automatic drive_wb(input logic v, input logic [2:0] op, input logic [3:0] sz,
                           input logic [31:0] addr, input logic [63:0] d);
      wb_valid = v; wb_opcode = op; wb_size = sz; wb_address = addr; wb_data = d;
      wb_param = 3'd2; wb_source = 2'd2;
   endtask

   bit rdy_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
   int fires;

   initial begin
      // ---------------- reset state ----------------
      reset_n = 1'b0;
      c_ready = 1'b0;
      d_release_ack = 1'b0;
      drive_prb(0, 3'd0, 4'd0, 32'h0, 64'h0);
      drive_wb (0, 3'd0, 4'd0, 32'h0, 64'h0);
      #1;
      check("rst_busy",        busy,        1'b0);
      check("rst_rel_pending", rel_pending, 1'b0);
      check("rst_proto_err",   proto_err,   1'b0);
      check("rst_c_valid",     c_valid,     1'b0);
      check("rst_prb_ready",   prb_ready,   1'b0);
      check("rst_wb_ready",    wb_ready,    1'b0);
      tick();
      tick();
      reset_n = 1'b1;
      c_ready = 1'b1;

      // ---------------- probe 8-beat burst beats a waiting Release ----------------
      drive_wb(1, 3'd6, 4'd6, 32'h2000, 64'h0);
      for (int i = 0; i < 8; i++) begin
         drive_prb(1, 3'd5, 4'd6, 32'h1000, 64'(100 + i));
         #1;
         check("A_c_valid",   c_valid,   1'b1);
         check("A_c_opcode",  c_opcode,  3'd5);
         check("A_c_data",    c_data,    64'(100 + i));
         check("A_prb_ready", prb_ready, 1'b1);
         check("A_wb_ready",  wb_ready,  1'b0);
         tick();
         check("A_busy", busy, (i < 7) ? 1'b1 : 1'b0);
      end
      drive_prb(0, 3'd0, 4'd0, 32'h0, 64'h0);
      #1;
      check("A_rel_c_valid",  c_valid,   1'b1);
      check("A_rel_c_opcode", c_opcode,  3'd6);
      check("A_rel_wb_ready", wb_ready,  1'b1);
      check("A_rel_addr",     c_address, 32'h2000);
      tick();
      check("A_rel_pending_set", rel_pending, 1'b1);
      check("A_rel_busy",        busy,        1'b0);

      // ---------------- ProbeAck passes while a Release is pending ----------------
      drive_wb(1, 3'd6, 4'd6, 32'h3000, 64'h0);
      drive_prb(1, 3'd4, 4'd6, 32'h1040, 64'h0);
      #1;
      check("C_c_valid",   c_valid,   1'b1);
      check("C_c_opcode",  c_opcode,  3'd4);
      check("C_prb_ready", prb_ready, 1'b1);
      check("C_wb_ready",  wb_ready,  1'b0);
      tick();
      check("C_rel_pending_held", rel_pending, 1'b1);

      // ---------------- second Release stalls until ReleaseAck ----------------
      drive_prb(0, 3'd0, 4'd0, 32'h0, 64'h0);
      #1;
      check("B_blocked_c_valid",  c_valid,  1'b0);
      check("B_blocked_wb_ready", wb_ready, 1'b0);
      d_release_ack = 1'b1;
      tick();
      d_release_ack = 1'b0;
      check("B_ack_clears",   rel_pending, 1'b0);
      check("B_ack_no_error", proto_err,   1'b0);
      #1;
      check("B_second_c_valid",  c_valid,   1'b1);
      check("B_second_wb_ready", wb_ready,  1'b1);
      check("B_second_addr",     c_address, 32'h3000);
      tick();
      check("B_second_pending", rel_pending, 1'b1);
      drive_wb(0, 3'd0, 4'd0, 32'h0, 64'h0);
      d_release_ack = 1'b1;
      tick();
      d_release_ack = 1'b0;
      check("B_second_ack", rel_pending, 1'b0);

      // ---------------- ReleaseData with c_ready toggling 1,0,0,1 ----------------
      fires = 0;
      for (int cyc = 0; cyc < 40 && fires < 8; cyc++) begin
         drive_wb(1, 3'd7, 4'd6, 32'h4000, 64'(200 + fires));
         c_ready = rdy_pat[cyc % 4];
         if (fires > 0) drive_prb(1, 3'd4, 4'd6, 32'h5000, 64'h0);
         else           drive_prb(0, 3'd0, 4'd0, 32'h0, 64'h0);
         #1;
         check("D_c_valid",     c_valid,   1'b1);
         check("D_c_opcode",    c_opcode,  3'd7);
         check("D_c_data",      c_data,    64'(200 + fires));
         check("D_wb_ready",    wb_ready,  c_ready);
         check("D_prb_blocked", prb_ready, 1'b0);
         if (c_ready) fires++;
         tick();
         check("D_busy", busy, (fires < 8) ? 1'b1 : 1'b0);
      end
      drive_prb(0, 3'd0, 4'd0, 32'h0, 64'h0);
      drive_wb(0, 3'd0, 4'd0, 32'h0, 64'h0);
      c_ready = 1'b1;
      check("D_fires",       32'(fires),  32'd8);
      check("D_rel_pending", rel_pending, 1'b1);
      d_release_ack = 1'b1;
      tick();
      d_release_ack = 1'b0;
      check("D_ack_clears", rel_pending, 1'b0);
      check("D_no_error",   proto_err,   1'b0);

      // ---------------- ProbeAckData size 7: error, clamped to 8 beats ----------------
      for (int i = 0; i < 8; i++) begin
         drive_prb(1, 3'd5, 4'd7, 32'h6000, 64'(300 + i));
         #1;
         check("F_c_data", c_data, 64'(300 + i));
         tick();
         check("F_busy", busy, (i < 7) ? 1'b1 : 1'b0);
         if (i == 0) check("F_proto_err_set", proto_err, 1'b1);
      end
      drive_prb(0, 3'd0, 4'd0, 32'h0, 64'h0);
      tick();
      check("F_proto_err_sticky", proto_err, 1'b1);

      // ---------------- reset mid-burst with a Release pending ----------------
      drive_wb(1, 3'd6, 4'd6, 32'h7000, 64'h0);
      tick();
      drive_wb(0, 3'd0, 4'd0, 32'h0, 64'h0);
      check("G_setup_pending", rel_pending, 1'b1);
      for (int i = 0; i < 2; i++) begin
         drive_prb(1, 3'd5, 4'd6, 32'h8000, 64'(400 + i));
         tick();
      end
      drive_prb(1, 3'd5, 4'd6, 32'h8000, 64'd402);
      #1;
      check("G_beat3_data", c_data, 64'd402);
      check("G_beat3_busy", busy,   1'b1);
      reset_n = 1'b0;
      #1;
      check("G_async_busy",        busy,        1'b0);
      check("G_async_rel_pending", rel_pending, 1'b0);
      check("G_async_proto_err",   proto_err,   1'b0);
      drive_prb(0, 3'd0, 4'd0, 32'h0, 64'h0);
      tick();
      check("G_edge_busy", busy, 1'b0);
      reset_n = 1'b1;
      drive_wb(1, 3'd6, 4'd6, 32'h9000, 64'h0);
      #1;
      check("G_idle_c_valid",   c_valid,   1'b1);
      check("G_idle_c_opcode",  c_opcode,  3'd6);
      check("G_idle_prb_ready", prb_ready, 1'b0);
      drive_wb(0, 3'd0, 4'd0, 32'h0, 64'h0);
      #1;
      check("G_idle_c_valid_low", c_valid, 1'b0);

      // ---------------- stray ReleaseAck ----------------
      d_release_ack = 1'b1;
      tick();
      d_release_ack = 1'b0;
      check("E_proto_err",   proto_err,   1'b1);
      check("E_rel_pending", rel_pending, 1'b0);
      repeat (3) tick();
      check("E_proto_err_sticky", proto_err, 1'b1);

      // ---------------- single-beat ReleaseData with same-cycle ack ----------------
      reset_n = 1'b0;
      #1;
      check("H_reset_proto_err", proto_err, 1'b0);
      reset_n = 1'b1;
      drive_wb(1, 3'd7, 4'd3, 32'hA000, 64'h55);
      d_release_ack = 1'b1;
      #1;
      check("H_c_valid", c_valid, 1'b1);
      tick();
      d_release_ack = 1'b0;
      drive_wb(0, 3'd0, 4'd0, 32'h0, 64'h0);
      check("H_set_wins",  rel_pending, 1'b1);
      check("H_proto_err", proto_err,   1'b1);
      check("H_no_burst",  busy,        1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
